// File: rtl/div_issue.sv
// div_issue: issue/retire front-end for the radix-4 SRT divider div32.
// Queues RISC-V DIV/DIVU/REM/REMU ops with a ROB tag. Divide-by-zero and
// signed overflow are answered locally. Every other op is launched into
// div32. The quotient or remainder is returned on a valid/ready port.
// A flush kills all queued work and discards any result still in flight.
module div_issue #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_in_en,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  output logic             div_signed,
  input  logic             div_idle,
  input  logic             div_out_en,
  input  logic [31:0]      div_q,
  input  logic [31:0]      div_rem
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = 2 + 32 + 32 + TAG_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // True when the op can be answered without the divider.
  function automatic logic is_corner(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic by_zero;
    logic ovf;
    by_zero = (b == 32'h0000_0000);
    ovf     = ~op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    return by_zero || ovf;
  endfunction

  // Architectural result for the locally resolved cases.
  function automatic logic [31:0] corner_result(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
    logic [31:0] res;
    if (b == 32'h0000_0000) begin
      res = op[1] ? a : 32'hFFFF_FFFF;
    end else begin
      res = op[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
    return res;
  endfunction

  // FIFO storage and control
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic             push_s;
  logic             pop_s;
  logic             fifo_empty_s;
  logic [ENT_W-1:0] head_s;
  logic [1:0]       head_op_s;
  logic [31:0]      head_a_s;
  logic [31:0]      head_b_s;
  logic [TAG_W-1:0] head_tag_s;

  // FSM and output registers
  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             div_in_en_q, div_in_en_d;
  logic [31:0]      div_a_q, div_a_d;
  logic [31:0]      div_b_q, div_b_d;
  logic             div_signed_q, div_signed_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  assign fifo_empty_s = (cnt_q == CNT_W'(0));
  assign in_ready     = (cnt_q != FULL_CNT) && !flush;
  assign push_s       = in_valid && in_ready;

  assign head_s     = mem_q[rd_ptr_q];
  assign head_op_s  = head_s[ENT_W-1 -: 2];
  assign head_a_s   = head_s[ENT_W-3 -: 32];
  assign head_b_s   = head_s[TAG_W+31 -: 32];
  assign head_tag_s = head_s[TAG_W-1:0];

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_tag    = out_tag_q;
  assign div_in_en  = div_in_en_q;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign div_signed = div_signed_q;

  // FIFO pointers, occupancy and entry storage; flush empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {in_op, in_a, in_b, in_tag};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'h0000_0000;
      out_tag_q    <= '0;
      div_in_en_q  <= 1'b0;
      div_a_q      <= 32'h0000_0000;
      div_b_q      <= 32'h0000_0000;
      div_signed_q <= 1'b0;
      op_q         <= 2'b00;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      div_in_en_q  <= div_in_en_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      div_signed_q <= div_signed_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
    end
  end

  // Next-state logic: pop/launch, result capture, handshake, flush and drain.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_tag_d    = out_tag_q;
    div_in_en_d  = 1'b0;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    div_signed_d = div_signed_q;
    op_d         = op_q;
    tag_d        = tag_q;
    pop_s        = 1'b0;

    if (flush) begin
      // Flush wins over everything. An op still inside div32 must be drained,
      // unless its result strobes in this very cycle and can be dropped now.
      out_valid_d = 1'b0;
      case (state_q)
        S_BUSY:  state_d = div_out_en ? S_IDLE : S_DRAIN;
        S_DRAIN: state_d = div_out_en ? S_IDLE : S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty_s && div_idle) begin
            pop_s = 1'b1;
            if (is_corner(head_op_s, head_a_s, head_b_s)) begin
              out_data_d  = corner_result(head_op_s, head_a_s, head_b_s);
              out_tag_d   = head_tag_s;
              out_valid_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              div_a_d      = head_a_s;
              div_b_d      = head_b_s;
              div_signed_d = ~head_op_s[0];
              div_in_en_d  = 1'b1;
              op_d         = head_op_s;
              tag_d        = head_tag_s;
              state_d      = S_BUSY;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BUSY: begin
          if (div_out_en) begin
            out_data_d  = op_q[1] ? div_rem : div_q;
            out_tag_d   = tag_q;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DRAIN: begin
          if (div_out_en) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue.sv
// Directed testbench for div_issue with a behavioural div32 stand-in.
module tb_div_issue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        div_in_en;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_signed;
  logic        div_idle;
  logic        div_out_en;
  logic [31:0] div_q;
  logic [31:0] div_rem;

  int vectors;
  int miscompares;

  // divider stand-in state
  int          m_lat;
  bit          m_busy;
  int          m_cnt;
  bit          force_busy;
  int          launch_cnt;
  int          bad_launch;
  int          strobe_cnt;
  logic        last_signed;
  logic [31:0] m_q;
  logic [31:0] m_r;

  div_issue #(.TAG_W(4), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .div_in_en(div_in_en), .div_a(div_a), .div_b(div_b), .div_signed(div_signed),
    .div_idle(div_idle), .div_out_en(div_out_en), .div_q(div_q), .div_rem(div_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign div_idle = !m_busy && !force_busy;

  // div32 stand-in: samples the launch pulse mid-cycle, answers m_lat cycles later.
  always @(negedge clk) begin
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    div_out_en = 1'b0;
    if (div_in_en) begin
      if (m_busy || force_busy) bad_launch++;
      launch_cnt++;
      last_signed = div_signed;
      sa = div_a;
      sb = div_b;
      if (div_b == 32'd0) begin
        m_q = 32'hFFFF_FFFF;
        m_r = div_a;
      end else if (div_signed) begin
        m_q = sa / sb;
        m_r = sa % sb;
      end else begin
        m_q = div_a / div_b;
        m_r = div_a % div_b;
      end
      m_busy = 1'b1;
      m_cnt  = m_lat;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy     = 1'b0;
        div_out_en = 1'b1;
        div_q      = m_q;
        div_rem    = m_r;
        strobe_cnt++;
      end else begin
        m_cnt--;
      end
    end
  end

  task automatic push_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    int n;
    n  = 0;
    ok = out_valid;
    while (!ok && n < bound) begin
      @(posedge clk); #1;
      n++;
      ok = out_valid;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({in_ready, out_valid, div_in_en, div_signed} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 1000", {in_ready, out_valid, div_in_en, div_signed});
    end
    vectors++;
    if ({out_data, out_tag, div_a, div_b} !== 100'd0) begin
      miscompares++;
      $display("FAIL reset_data: got data=%h tag=%h a=%h b=%h want all 0", out_data, out_tag, div_a, div_b);
    end
  endtask

  task automatic test_signed_div();
    bit ok;
    int l0;
    l0 = launch_cnt;
    push_op(2'b00, 32'hFFFF_FFF9, 32'd2, 4'd3);
    vectors++;
    if (div_in_en !== 1'b0) begin
      miscompares++;
      $display("FAIL div_launch_early: got %b want 0", div_in_en);
    end
    @(posedge clk); #1;
    vectors++;
    if ({div_in_en, div_signed, div_a, div_b} !== {1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2}) begin
      miscompares++;
      $display("FAIL div_launch: got en=%b s=%b a=%h b=%h want 1 1 fffffff9 2", div_in_en, div_signed, div_a, div_b);
    end
    wait_valid(60, ok);
    vectors++;
    if (!ok || out_data !== 32'hFFFF_FFFD || out_tag !== 4'd3) begin
      miscompares++;
      $display("FAIL div_result: got v=%b data=%h tag=%0d want fffffffd tag 3", ok, out_data, out_tag);
    end
    vectors++;
    if (launch_cnt - l0 !== 1) begin
      miscompares++;
      $display("FAIL div_launch_count: got %0d want 1", launch_cnt - l0);
    end
    accept();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL div_retire: got out_valid=%b want 0", out_valid);
    end
    push_op(2'b10, 32'hFFFF_FFF9, 32'd2, 4'd4);
    wait_valid(60, ok);
    vectors++;
    if (!ok || out_data !== 32'hFFFF_FFFF || out_tag !== 4'd4 || last_signed !== 1'b1) begin
      miscompares++;
      $display("FAIL rem_result: got v=%b data=%h tag=%0d s=%b want ffffffff tag 4 s 1", ok, out_data, out_tag, last_signed);
    end
    accept();
  endtask

  task automatic test_div_by_zero();
    bit ok;
    int l0;
    l0 = launch_cnt;
    push_op(2'b01, 32'd5, 32'd0, 4'd5);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dz_early: got out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, out_data, out_tag} !== {1'b1, 32'hFFFF_FFFF, 4'd5}) begin
      miscompares++;
      $display("FAIL divu_by_zero: got v=%b data=%h tag=%0d want 1 ffffffff 5", out_valid, out_data, out_tag);
    end
    accept();
    push_op(2'b11, 32'd5, 32'd0, 4'd6);
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, out_data, out_tag} !== {1'b1, 32'd5, 4'd6}) begin
      miscompares++;
      $display("FAIL remu_by_zero: got v=%b data=%h tag=%0d want 1 5 6", out_valid, out_data, out_tag);
    end
    accept();
    wait_valid(1, ok);
    vectors++;
    if (launch_cnt - l0 !== 0) begin
      miscompares++;
      $display("FAIL dz_no_launch: got %0d launches want 0", launch_cnt - l0);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int l0;
    l0 = launch_cnt;
    push_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7);
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, out_data, out_tag} !== {1'b1, 32'h8000_0000, 4'd7}) begin
      miscompares++;
      $display("FAIL div_ovf: got v=%b data=%h tag=%0d want 1 80000000 7", out_valid, out_data, out_tag);
    end
    accept();
    push_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8);
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, out_data, out_tag} !== {1'b1, 32'h0, 4'd8}) begin
      miscompares++;
      $display("FAIL rem_ovf: got v=%b data=%h tag=%0d want 1 0 8", out_valid, out_data, out_tag);
    end
    accept();
    vectors++;
    if (launch_cnt - l0 !== 0) begin
      miscompares++;
      $display("FAIL ovf_no_launch: got %0d launches want 0", launch_cnt - l0);
    end
    push_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9);
    wait_valid(60, ok);
    vectors++;
    if (!ok || out_data !== 32'h0 || out_tag !== 4'd9 || launch_cnt - l0 !== 1 || last_signed !== 1'b0) begin
      miscompares++;
      $display("FAIL divu_ovf_operands: got v=%b data=%h tag=%0d launches=%0d s=%b want 0 tag 9 1 launch s 0",
               ok, out_data, out_tag, launch_cnt - l0, last_signed);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int l0;
    l0 = launch_cnt;
    push_op(2'b01, 32'd100, 32'd7, 4'd0);
    push_op(2'b01, 32'd100, 32'd7, 4'd1);
    push_op(2'b01, 32'd100, 32'd7, 4'd2);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_full_ready: got in_ready=%b want 0", in_ready);
    end
    wait_valid(60, ok);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({out_valid, out_data, out_tag} !== {1'b1, 32'd14, 4'd0}) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: got v=%b data=%0d tag=%0d want 1 14 0", i, out_valid, out_data, out_tag);
      end
      @(posedge clk); #1;
    end
    accept();
    for (int t = 1; t < 3; t++) begin
      wait_valid(60, ok);
      vectors++;
      if (!ok || out_data !== 32'd14 || out_tag !== 4'(t)) begin
        miscompares++;
        $display("FAIL b2b_order[%0d]: got v=%b data=%0d tag=%0d want 14 tag %0d", t, ok, out_data, out_tag, t);
      end
      accept();
    end
    vectors++;
    if (launch_cnt - l0 !== 3) begin
      miscompares++;
      $display("FAIL b2b_launches: got %0d want 3", launch_cnt - l0);
    end
  endtask

  task automatic test_flush();
    bit ok;
    bit seen_valid;
    int s0;
    int n;
    push_op(2'b01, 32'd100, 32'd7, 4'd10);
    n = 0;
    while (div_in_en !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (5) begin
      @(posedge clk); #1;
    end
    s0 = strobe_cnt;
    flush = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: got in_ready=%b want 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    push_op(2'b11, 32'd100, 32'd7, 4'd11);
    seen_valid = out_valid;
    n = 0;
    while (strobe_cnt == s0 && n < 60) begin
      @(posedge clk); #1;
      seen_valid = seen_valid | out_valid;
      n++;
    end
    vectors++;
    if (seen_valid !== 1'b0 || strobe_cnt == s0) begin
      miscompares++;
      $display("FAIL flush_drop: got out_valid_seen=%b strobes=%0d want 0 and 1", seen_valid, strobe_cnt - s0);
    end
    wait_valid(60, ok);
    vectors++;
    if (!ok || out_data !== 32'd2 || out_tag !== 4'd11) begin
      miscompares++;
      $display("FAIL remu_after_flush: got v=%b data=%0d tag=%0d want 2 tag 11", ok, out_data, out_tag);
    end
    accept();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int l0;
    int n;
    push_op(2'b01, 32'd100, 32'd7, 4'd12);
    n = 0;
    while (div_in_en !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    force_busy = 1'b1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, div_in_en, div_signed, out_data, out_tag, div_a, div_b} !== {4'b1000, 100'd0}) begin
      miscompares++;
      $display("FAIL reset_mid: got rdy=%b v=%b en=%b s=%b data=%h tag=%h a=%h b=%h want 1 0 0 0 all-zero",
               in_ready, out_valid, div_in_en, div_signed, out_data, out_tag, div_a, div_b);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    l0 = launch_cnt;
    push_op(2'b00, 32'd100, 32'd7, 4'd13);
    repeat (10) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (launch_cnt !== l0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_not_idle: got launches=%0d v=%b want 0 0", launch_cnt - l0, out_valid);
    end
    n = 0;
    while (m_busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    force_busy = 1'b0;
    wait_valid(60, ok);
    vectors++;
    if (!ok || out_data !== 32'd14 || out_tag !== 4'd13 || launch_cnt - l0 !== 1) begin
      miscompares++;
      $display("FAIL after_reset: got v=%b data=%0d tag=%0d launches=%0d want 14 tag 13 1", ok, out_data, out_tag, launch_cnt - l0);
    end
    accept();
    vectors++;
    if (bad_launch !== 0) begin
      miscompares++;
      $display("FAIL launch_while_busy: got %0d want 0", bad_launch);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_lat       = 20;
    m_busy      = 1'b0;
    m_cnt       = 0;
    force_busy  = 1'b0;
    launch_cnt  = 0;
    bad_launch  = 0;
    strobe_cnt  = 0;
    last_signed = 1'b0;
    m_q         = 32'd0;
    m_r         = 32'd0;
    div_out_en  = 1'b0;
    div_q       = 32'd0;
    div_rem     = 32'd0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_op       = 2'b00;
    in_a        = 32'd0;
    in_b        = 32'd0;
    in_tag      = 4'd0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_signed_div();
    test_div_by_zero();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_issue.md
# div_issue

Issue/retire front-end for the radix-4 SRT divider `div32`, sitting between the ALU dispatch path and the divider. It accepts RISC-V M-extension divide/remainder ops (DIV, DIVU, REM, REMU) with a ROB tag into a small FIFO. Divide-by-zero and signed overflow are resolved locally without using the divider. All other ops are launched into `div32`, whose result is captured, the quotient or remainder is selected, and the result is presented on a valid/ready output port; a flush discards all queued and in-flight work.

## Interface
- TAG_W, 4, width of ROB tag carried with each op
- DEPTH, 2, input FIFO entries (power of two, ≥2)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- flush  in  1  synchronous kill of all queued/in-flight ops
- in_valid  in  1  op offered
- in_ready  out  1  FIFO not full and flush=0
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- in_a, in_b  in  32  dividend, divisor
- in_tag  in  TAG_W  ROB tag
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_data  out  32  quotient or remainder
- out_tag  out  TAG_W  tag of result
- div_in_en  out  1  one-cycle launch pulse to `div32`
- div_a, div_b  out  32  operands to `div32`
- div_signed  out  1  signed-mode select to `div32`
- div_idle  in  1  `div32` idle
- div_out_en  in  1  `div32` result strobe
- div_q, div_rem  in  32  `div32` results

## Operation
- FIFO: push on in_valid&&in_ready; pop only in IDLE. Pointers wrap modulo DEPTH; a count register distinguishes full from empty.
- States: IDLE, BUSY, DONE, DRAIN.
- IDLE, FIFO non-empty, div_idle=1: pop head.
  - Corner case: load output regs and go to DONE.
    - b==0: quotient 0xFFFFFFFF, remainder a.
    - Signed op with a==0x80000000, b==0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - Otherwise: register div_a=a, div_b=b, div_signed=~op[0], pulse div_in_en, latch op/tag, go to BUSY.
- IDLE with div_idle=0: stall, no pop.
- BUSY: on div_out_en, out_data = op[1] ? div_rem : div_q; out_tag = latched tag; go to DONE.
- DONE: out_valid=1, out_data/out_tag stable. On out_ready, go to IDLE.
- flush (highest priority, overrides push/pop/handshake):
  - Clear the FIFO and drop out_valid.
  - BUSY goes to DRAIN; DONE and IDLE go to IDLE.
  - A flush in the same cycle as div_out_en in BUSY goes to IDLE and discards the result.
- DRAIN: wait for div_out_en, discard the result, go to IDLE. Pushes are accepted during DRAIN.
- No arithmetic beyond 32-bit equality compares; `div32` performs sign fix-up.

## Timing
- Reset values:
  - in_ready=1 (FIFO empty).
  - out_valid=0, out_data=0, out_tag=0.
  - div_in_en=0, div_a=0, div_b=0, div_signed=0.
  - State IDLE, FIFO empty.
- Push at cycle N gives the earliest pop at N+1.
- Corner-case path: out_valid high at N+2.
- Normal path: div_in_en high for exactly one cycle (N+2), never while div_idle=0.
  - `div32` returns ~20 cycles later; the block must not rely on the exact count.
- div_out_en at cycle D gives out_valid at D+1.
- out_valid&&out_ready at cycle E: out_valid low at E+1. The next pop is evaluated at E+1, so the next result is no earlier than E+2.
- in_ready is combinational from count and flush. A push and a pop in the same cycle keep the count unchanged.
- Reset mid-operation: all state clears immediately. After rst_n rises, no launch occurs until div_idle=1.

## Test plan
- DIV a=0xFFFFFFF9 (-7), b=2, tag 3 → one div_in_en with div_signed=1; out_data=0xFFFFFFFD, out_tag=3. REM of the same operands → 0xFFFFFFFF.
- DIVU 5/0 → out_data=0xFFFFFFFF; REMU 5/0 → 5. No div_in_en in either case; out_valid two cycles after push.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; DIVU of the same operands launches the divider and returns 0.
- Three back-to-back DIVU 100/7 pushes with DEPTH=2 → in_ready low while the FIFO is full. Hold out_ready=0 for 10 cycles: out_valid and out_data=14 stay stable. Results retire in push order (tags 0,1,2).
- flush 5 cycles after div_in_en → out_valid stays 0 and the late div_out_en result is dropped. A subsequent REMU 100/7 returns 2.
- Assert rst_n=0 while BUSY → all outputs return to reset values at once. No div_in_en until div_idle=1.
